// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-sequenced data memory.
//   state_e : access sequencer states
//   LANE_W  : width of one byte lane / one RAM word
//   lanes() : number of byte lanes in a data word
package mem_pkg;

    localparam int unsigned LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic int unsigned lanes(input int unsigned data_w);
        return data_w / LANE_W;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// DEPTH x 8 single-port RAM, synchronous write, one-cycle registered read.
//   clk     : clock
//   en_i    : access enable
//   we_i    : 1 = write wdata_i, 0 = read into rdata_o
//   addr_i  : byte address
//   wdata_i : write byte
//   rdata_o : read byte, valid the cycle after a read access
module byte_ram #(
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage array has no reset; read port is a plain output register.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/byte_seq_memory.sv
// Word-wide data memory built on a byte RAM: each access runs a fixed
// BYTES+3 cycle sequence (accept, BYTES beats, drain, response).
//   clk, rst_n         : clock, async active-low reset
//   req_valid/req_ready: request handshake, ready only when idle
//   req_we, req_addr   : direction, address of the most-significant byte
//   req_wdata, req_be  : write data and per-lane enables
//   rsp_valid          : one-cycle completion pulse
//   rsp_rdata, rsp_err : read data (0 for writes/errors), range error
module byte_seq_memory
    import mem_pkg::*;
#(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned DEPTH  = 16384,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/LANE_W-1:0] req_be,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err
);

    localparam int unsigned BYTES  = lanes(DATA_W);
    localparam int unsigned BEAT_W = $clog2(BYTES);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]    be_q, be_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                addr_err_c;
    int unsigned         beat_i;
    logic                ram_en_c;
    logic                ram_we_c;
    logic [ADDR_W-1:0]   ram_addr_c;
    logic [7:0]          ram_wdata_c;
    logic [7:0]          ram_rdata;

    // Compare at 32 bits so an address equal to DEPTH is not lost to truncation.
    assign addr_err_c = (32'(req_addr) < (BYTES - 1)) || (32'(req_addr) >= DEPTH);

    assign beat_i      = 32'(beat_q);
    // Errored accesses never touch the RAM; disabled lanes still burn a beat.
    assign ram_en_c    = (state_q == XFER) && !err_q;
    assign ram_we_c    = we_q && be_q[beat_q];
    assign ram_addr_c  = base_q + ADDR_W'(beat_q);
    assign ram_wdata_c = wdata_q[beat_i*LANE_W +: LANE_W];

    byte_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_c),
        .we_i    (ram_we_c),
        .addr_i  (ram_addr_c),
        .wdata_i (ram_wdata_c),
        .rdata_o (ram_rdata)
    );

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cap_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            we_q        <= we_d;
            err_q       <= err_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            cap_q       <= cap_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Sequencer next-state and output logic.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        we_d        = we_q;
        err_d       = err_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cap_d       = cap_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d      = req_we;
                    err_d     = addr_err_c;
                    base_d    = req_addr - ADDR_W'(BYTES - 1);
                    wdata_d   = req_wdata;
                    be_d      = req_be;
                    beat_d    = '0;
                    cap_d     = '0;
                    rsp_err_d = 1'b0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                // Byte read by the previous beat lands now.
                if (beat_q != '0) begin
                    cap_d[(beat_i-1)*LANE_W +: LANE_W] = ram_rdata;
                end
                if (beat_q == BEAT_W'(BYTES - 1)) begin
                    state_d = DRAIN;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            DRAIN: begin
                // Most-significant byte lands this cycle; merge it directly.
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = (we_q || err_q) ? '0
                                              : {ram_rdata, cap_q[DATA_W-LANE_W-1:0]};
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_byte_seq_memory.sv
// Randomised self-checking bench for byte_seq_memory with DATA_W=16 and 32.
module tb_byte_seq_memory;

    localparam int unsigned DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst_n, rst32_n;
    logic        valid16, valid32;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        rdy16, rv16, err16;
    logic [15:0] rd16;
    logic        rdy32, rv32, err32;
    logic [31:0] rd32;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference byte storage, one image per DUT (0 = 16-bit, 1 = 32-bit).
    logic [7:0] mem_m [2][DEPTH];

    always #5 clk = ~clk;

    byte_seq_memory #(.DATA_W(16), .DEPTH(DEPTH)) dut16 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid16), .req_ready(rdy16),
        .req_we(we), .req_addr(addr), .req_wdata(wdata[15:0]), .req_be(be[1:0]),
        .rsp_valid(rv16), .rsp_rdata(rd16), .rsp_err(err16)
    );

    byte_seq_memory #(.DATA_W(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst_n(rst32_n), .req_valid(valid32), .req_ready(rdy32),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_err(err32)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one access to the model: returns expected response, updates storage.
    task automatic model_access(input int s, input logic w, input logic [13:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                output logic [31:0] rd, output logic er);
        int n    = (s != 0) ? 4 : 2;
        int base = int'(a) - (n - 1);
        er = (int'(a) < n - 1) || (int'(a) >= int'(DEPTH));
        rd = '0;
        if (!er) begin
            for (int j = 0; j < n; j++) begin
                if (w) begin
                    if (b[j]) mem_m[s][base+j] = d[8*j +: 8];
                end else begin
                    rd[8*j +: 8] = mem_m[s][base+j];
                end
            end
        end
    endtask

    function automatic logic [31:0] obs_rd(input int s);
        return (s != 0) ? rd32 : {16'h0, rd16};
    endfunction

    // One complete access; entered and left at posedge+1 with the DUT idle.
    task automatic access(input int s, input logic w, input logic [13:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          lat;
        int          n = (s != 0) ? 4 : 2;
        model_access(s, w, a, d, b, exp_rd, exp_er);
        check_eq("ready_idle", (s != 0) ? rdy32 : rdy16, 1);
        we = w; addr = a; wdata = d; be = b;
        if (s != 0) valid32 = 1'b1; else valid16 = 1'b1;
        @(posedge clk); #1;
        valid16 = 1'b0; valid32 = 1'b0;
        // Junk on the request bus must be ignored while busy.
        we = 1'($urandom); addr = 14'($urandom); wdata = $urandom; be = 4'($urandom);
        lat = 1;
        check_eq("ready_busy", (s != 0) ? rdy32 : rdy16, 0);
        check_eq("err_cleared", (s != 0) ? err32 : err16, 0);
        while (!((s != 0) ? rv32 : rv16) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(n + 2));
        check_eq("rdata", obs_rd(s), exp_rd);
        check_eq("err", (s != 0) ? err32 : err16, exp_er);
        @(posedge clk); #1;
        check_eq("rsp_pulse", (s != 0) ? rv32 : rv16, 0);
        check_eq("ready_after", (s != 0) ? rdy32 : rdy16, 1);
        check_eq("rdata_held", obs_rd(s), exp_rd);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] ba [3];
        logic        bw [3];
        logic [31:0] expq [$];
        logic        expe [$];
        logic [31:0] e_rd;
        logic        e_er;
        int          acc [3];
        int          nacc, nrsp;
        logic        took;
        logic        saw_rsp;

        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_m[0][i] = 8'h0;
            mem_m[1][i] = 8'h0;
        end
        rst_n = 1'b0; rst32_n = 1'b0;
        valid16 = 1'b0; valid32 = 1'b0;
        we = 1'b0; addr = '0; wdata = '0; be = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready16", rdy16, 1);
        check_eq("rst_valid16", rv16, 0);
        check_eq("rst_rdata16", 32'(rd16), 0);
        check_eq("rst_err16", err16, 0);
        check_eq("rst_ready32", rdy32, 1);
        check_eq("rst_rdata32", rd32, 0);
        rst_n = 1'b1; rst32_n = 1'b1;
        @(posedge clk); #1;

        // Fill the random-test window so every read hits known bytes.
        for (int a = 1; a < 64; a += 2) access(0, 1'b1, 14'(a), $urandom, 4'b0011);

        // Directed lane and range cases.
        access(0, 1'b1, 14'h0011, 32'hBEEF, 4'b0011);
        access(0, 1'b0, 14'h0011, 32'h0, 4'b0000);
        check_eq("beef_direct", obs_rd(0), 32'hBEEF);
        access(0, 1'b1, 14'h0011, 32'h1234, 4'b0001);
        access(0, 1'b0, 14'h0011, 32'h0, 4'b0000);
        check_eq("be34_direct", obs_rd(0), 32'hBE34);
        access(0, 1'b0, 14'h0000, 32'h0, 4'b0000);
        check_eq("err_addr0", err16, 1);
        access(0, 1'b1, 14'(DEPTH), 32'hFFFF, 4'b0011);   // 16384 wraps to 0 on the port
        access(0, 1'b0, 14'h0001, 32'h0, 4'b0000);        // byte 0 must be untouched
        access(0, 1'b1, 14'(DEPTH - 1), 32'hA5A5, 4'b0011);
        access(0, 1'b0, 14'(DEPTH - 1), 32'h0, 4'b0000);
        check_eq("a5a5_direct", obs_rd(0), 32'hA5A5);

        // Random traffic over the window, including the low-boundary error.
        for (int i = 0; i < 40; i++) begin
            access(0, 1'($urandom), 14'($urandom_range(0, 63)), $urandom, 4'($urandom));
        end

        // Back-to-back with req_valid held high.
        ba[0] = 14'h0020; ba[1] = 14'h0020; ba[2] = 14'h0021;
        bw[0] = 1'b1;     bw[1] = 1'b0;     bw[2] = 1'b0;
        nacc = 0; nrsp = 0;
        we = bw[0]; addr = ba[0]; wdata = 32'hC0DE; be = 4'b0011;
        valid16 = 1'b1;
        for (int c = 0; c < 40 && nrsp < 3; c++) begin
            took = 1'b0;
            if (rv16) begin
                if (expq.size() > 0) begin
                    check_eq("b2b_rdata", 32'(rd16), expq.pop_front());
                    check_eq("b2b_err", err16, expe.pop_front());
                end else begin
                    check_eq("b2b_extra_rsp", rv16, 0);
                end
                nrsp++;
            end
            if (rdy16 && valid16) begin
                acc[nacc] = c;
                model_access(0, we, addr, wdata, be, e_rd, e_er);
                expq.push_back(e_rd);
                expe.push_back(e_er);
                nacc++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                if (nacc < 3) begin
                    we = bw[nacc]; addr = ba[nacc];
                end else begin
                    valid16 = 1'b0;
                end
            end
        end
        valid16 = 1'b0;
        check_eq("b2b_rsp_count", 32'(nrsp), 3);
        check_eq("b2b_acc_count", 32'(nacc), 3);
        if (nacc == 3) begin
            check_eq("b2b_gap01", 32'(acc[1] - acc[0]), 5);
            check_eq("b2b_gap12", 32'(acc[2] - acc[1]), 5);
        end
        @(posedge clk); #1;

        // 32-bit: reset in the middle of a write.
        access(1, 1'b1, 14'h0103, 32'hA0B0C0D0, 4'b1111);
        access(1, 1'b0, 14'h0103, 32'h0, 4'b0000);
        check_eq("prior32", rd32, 32'hA0B0C0D0);
        we = 1'b1; addr = 14'h0103; wdata = 32'h11223344; be = 4'b1111;
        valid32 = 1'b1;
        @(posedge clk); #1;                  // cycle 1: beat 0 issued
        valid32 = 1'b0;
        @(posedge clk); #1;                  // cycle 2
        rst32_n = 1'b0;
        #1;
        check_eq("midrst_ready", rdy32, 1);
        check_eq("midrst_valid", rv32, 0);
        mem_m[1][14'h0100] = 8'h44;          // only the first beat completed
        @(posedge clk); #1;
        rst32_n = 1'b1;
        saw_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rv32) saw_rsp = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("midrst_no_rsp", saw_rsp, 0);
        access(1, 1'b0, 14'h0103, 32'h0, 4'b0000);
        check_eq("partial32", rd32, 32'hA0B0C044);
        access(1, 1'b1, 14'h0103, 32'h11223344, 4'b1111);
        access(1, 1'b0, 14'h0103, 32'h0, 4'b0000);
        check_eq("full32", rd32, 32'h11223344);
        access(1, 1'b0, 14'h0002, 32'h0, 4'b0000);
        check_eq("err32_low", err32, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
